ram4k_loader: RTL and testbench

Boot-time loader that sits directly upstream of the 4K-word RAM and is the only driver of its `in`, `addr` and `load` inputs while active. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. It writes the words to consecutive RAM addresses, then reads the same range back through the RAM's combinational `out` and compares checksums. Used to preload program or data images before the CPU is released.

---
 rtl/ram4k_loader_if.sv | 21 ++
 rtl/ram4k_loader.sv | 107 ++++++++++
 tb/tb_ram4k_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram4k_loader_if.sv
// Byte-stream handshake plus RAM port bundle for the 4K-word RAM loader.
// master = loader side, slave = byte source / RAM side.
interface ram4k_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] ram_out;
  logic [15:0] ram_in;
  logic [11:0] ram_addr;
  logic        ram_load;

  modport master (
    input  byte_in, byte_valid, ram_out,
    output byte_ready, ram_in, ram_addr, ram_load
  );

  modport slave (
    output byte_in, byte_valid, ram_out,
    input  byte_ready, ram_in, ram_addr, ram_load
  );
endinterface

// File: rtl/ram4k_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to
// consecutive RAM addresses, then reads the range back and compares checksums.
module ram4k_loader #(
  parameter int          WORD_COUNT = 4096,
  parameter logic [11:0] BASE_ADDR  = 12'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  ram4k_loader_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           checksum,
  output logic [2:0]            state_dbg
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
  // byte_ready depends only on state (HI or LO), never on byte_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HI     = 3'd1,
    S_LO     = 3'd2,
    S_WRITE  = 3'd3,
    S_VERIFY = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [11:0] LAST = 12'(WORD_COUNT - 1);

  state_t      state;
  logic [11:0] i;
  logic [15:0] wr_sum;
  logic [15:0] rd_sum;
  logic [15:0] word_q;
  logic        error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      i       <= 12'd0;
      wr_sum  <= 16'd0;
      rd_sum  <= 16'd0;
      word_q  <= 16'd0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_HI;
            i       <= 12'd0;
            wr_sum  <= 16'd0;
            rd_sum  <= 16'd0;
            error_q <= 1'b0;
          end
        end
        S_HI: begin
          if (bus.byte_valid) begin
            word_q[15:8] <= bus.byte_in;
            state        <= S_LO;
          end
        end
        S_LO: begin
          if (bus.byte_valid) begin
            word_q[7:0] <= bus.byte_in;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_sum <= wr_sum + word_q;
          if (i == LAST) begin
            i     <= 12'd0;
            state <= S_VERIFY;
          end else begin
            i     <= i + 12'd1;
            state <= S_HI;
          end
        end
        S_VERIFY: begin
          rd_sum <= rd_sum + bus.ram_out;
          // Fold in the final read word before comparing against the write side.
          if (i == LAST) begin
            i       <= 12'd0;
            error_q <= ((rd_sum + bus.ram_out) != wr_sum);
            state   <= S_DONE;
          end else begin
            i <= i + 12'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = (state == S_HI) || (state == S_LO);
  assign bus.ram_load   = (state == S_WRITE);
  assign bus.ram_in     = word_q;
  assign bus.ram_addr   = ((state == S_IDLE) || (state == S_DONE)) ? BASE_ADDR
                                                                   : BASE_ADDR + i;
  assign busy      = (state == S_HI) || (state == S_LO) ||
                     (state == S_WRITE) || (state == S_VERIFY);
  assign done      = (state == S_DONE);
  assign error     = error_q;
  assign checksum  = wr_sum;
  assign state_dbg = state;

endmodule

// File: tb/tb_ram4k_loader.sv
// Directed bench for ram4k_loader: two instances (2 words at base 0, 4 words
// at base 4094), each with its own behavioural RAM.
module tb_ram4k_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        fault;
  logic        sel;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [15:0] checksum_a, checksum_b;
  logic [2:0]  state_dbg_a, state_dbg_b;

  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];

  ram4k_loader_if bus_a ();
  ram4k_loader_if bus_b ();

  // clock/reset block
  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  ram4k_loader #(.WORD_COUNT(2), .BASE_ADDR(12'd0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .error(error_a),
    .checksum(checksum_a), .state_dbg(state_dbg_a)
  );

  ram4k_loader #(.WORD_COUNT(4), .BASE_ADDR(12'd4094)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .error(error_b),
    .checksum(checksum_b), .state_dbg(state_dbg_b)
  );

  assign bus_a.byte_in    = byte_in;
  assign bus_a.byte_valid = byte_valid;
  assign bus_b.byte_in    = byte_in;
  assign bus_b.byte_valid = byte_valid;

  // RAM models: synchronous write, combinational read; optional bit-0 flip
  // at address 1 while instance a is in VERIFY.
  wire verify_a = busy_a && !bus_a.byte_ready && !bus_a.ram_load;
  always @(posedge clk) begin
    if (bus_a.ram_load) mem_a[bus_a.ram_addr] <= bus_a.ram_in;
    if (bus_b.ram_load) mem_b[bus_b.ram_addr] <= bus_b.ram_in;
  end
  assign bus_a.ram_out = mem_a[bus_a.ram_addr] ^
                         {15'd0, fault && verify_a && (bus_a.ram_addr == 12'd1)};
  assign bus_b.ram_out = mem_b[bus_b.ram_addr];

  wire rdy = sel ? bus_b.byte_ready : bus_a.byte_ready;
  wire dn  = sel ? done_b : done_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all called at a falling edge and return at a falling edge
  task automatic start_load(output int t0);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (!dn && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", {31'd0, dn}, 32'd1);
    t = cyc;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0; fault = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_ready_a", {31'd0, bus_a.byte_ready}, 32'd0);
    chk("rst_load_a",  {31'd0, bus_a.ram_load},   32'd0);
    chk("rst_busy_a",  {31'd0, busy_a},           32'd0);
    chk("rst_done_a",  {31'd0, done_a},           32'd0);
    chk("rst_error_a", {31'd0, error_a},          32'd0);
    chk("rst_cks_a",   {16'd0, checksum_a},       32'h0000);
    chk("rst_ramin_a", {16'd0, bus_a.ram_in},     32'h0000);
    chk("rst_addr_a",  {20'd0, bus_a.ram_addr},   32'd0);
    chk("rst_addr_b",  {20'd0, bus_b.ram_addr},   32'd4094);

    // no-gap load of two words
    sel = 1'b0;
    start_load(t0);
    chk("hi_busy", {31'd0, busy_a}, 32'd1);
    send_word(16'h1234);
    send_word(16'hABCD);
    byte_valid = 1'b0;
    wait_done(t1);
    chk("nogap_latency", t1 - t0, 32'd8);
    chk("nogap_ram0",  {16'd0, mem_a[0]},   32'h1234);
    chk("nogap_ram1",  {16'd0, mem_a[1]},   32'hABCD);
    chk("nogap_cks",   {16'd0, checksum_a}, 32'hBE01);
    chk("nogap_error", {31'd0, error_a},    32'd0);
    chk("nogap_addr",  {20'd0, bus_a.ram_addr}, 32'd0);

    // same stream with a 5-cycle gap inside the first word
    start_load(t0);
    send_byte(8'h12);
    byte_valid = 1'b0;
    byte_in    = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      chk("gap_ready_lo", {31'd0, bus_a.byte_ready}, 32'd1);
      @(negedge clk);
    end
    send_byte(8'h34);
    send_word(16'hABCD);
    byte_valid = 1'b0;
    wait_done(t1);
    chk("gap_latency", t1 - t0, 32'd13);
    chk("gap_ram0",  {16'd0, mem_a[0]},   32'h1234);
    chk("gap_ram1",  {16'd0, mem_a[1]},   32'hABCD);
    chk("gap_cks",   {16'd0, checksum_a}, 32'hBE01);
    chk("gap_error", {31'd0, error_a},    32'd0);

    // address wrap on instance b
    sel = 1'b1;
    start_load(t0);
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'h0003);
    send_word(16'h0004);
    byte_valid = 1'b0;
    wait_done(t1);
    chk("wrap_4094",  {16'd0, mem_b[4094]}, 32'h0001);
    chk("wrap_4095",  {16'd0, mem_b[4095]}, 32'h0002);
    chk("wrap_0",     {16'd0, mem_b[0]},    32'h0003);
    chk("wrap_1",     {16'd0, mem_b[1]},    32'h0004);
    chk("wrap_cks",   {16'd0, checksum_b},  32'h000A);
    chk("wrap_error", {31'd0, error_b},     32'd0);
    chk("wrap_idle_a", {31'd0, done_a},     32'd1);

    // checksum overflow
    sel = 1'b0;
    start_load(t0);
    send_word(16'hFFFF);
    send_word(16'h0002);
    byte_valid = 1'b0;
    wait_done(t1);
    chk("ovf_cks",   {16'd0, checksum_a}, 32'h0001);
    chk("ovf_error", {31'd0, error_a},    32'd0);

    // read-back fault at address 1
    fault = 1'b1;
    start_load(t0);
    send_word(16'h1234);
    send_word(16'hABCD);
    byte_valid = 1'b0;
    wait_done(t1);
    fault = 1'b0;
    chk("fault_done",  {31'd0, done_a},     32'd1);
    chk("fault_error", {31'd0, error_a},    32'd1);
    chk("fault_cks",   {16'd0, checksum_a}, 32'hBE01);

    // reset during WRITE of the second word
    start_load(t0);
    chk("restart_clr_error", {31'd0, error_a}, 32'd0);
    send_word(16'h1122);
    send_word(16'h3344);
    byte_valid = 1'b0;
    chk("wr2_load", {31'd0, bus_a.ram_load}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_load",  {31'd0, bus_a.ram_load},   32'd0);
    chk("arst_busy",  {31'd0, busy_a},           32'd0);
    chk("arst_done",  {31'd0, done_a},           32'd0);
    chk("arst_error", {31'd0, error_a},          32'd0);
    chk("arst_cks",   {16'd0, checksum_a},       32'h0000);
    chk("arst_ready", {31'd0, bus_a.byte_ready}, 32'd0);
    chk("arst_ramin", {16'd0, bus_a.ram_in},     32'h0000);
    chk("arst_addr",  {20'd0, bus_a.ram_addr},   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_ram0_kept",   {16'd0, mem_a[0]}, 32'h1122);
    chk("arst_ram1_unwr",   {16'd0, mem_a[1]}, 32'hABCD);

    // clean load after the abort
    start_load(t0);
    send_word(16'h5555);
    send_word(16'h0001);
    byte_valid = 1'b0;
    wait_done(t1);
    chk("clean_latency", t1 - t0, 32'd8);
    chk("clean_ram0",  {16'd0, mem_a[0]},   32'h5555);
    chk("clean_ram1",  {16'd0, mem_a[1]},   32'h0001);
    chk("clean_cks",   {16'd0, checksum_a}, 32'h5556);
    chk("clean_error", {31'd0, error_a},    32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
